// File: rtl/draw_wrbuf_param.sv
// Draw-pixel to VRAM write buffer: synchronous FIFO on inferred RAM with
// standard or first-word-fall-through read, threshold flags and sticky errors.
module draw_wrbuf_param #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 8,
    parameter int unsigned AEMPTY_TH = 8,
    parameter int unsigned BURST_LEN = 8,
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic [DATA_W-1:0] PIXEL_DATA,
    input  logic              BUF_WR,
    input  logic              BUF_RD,
    input  logic              ERR_CLR,
    output logic [DATA_W-1:0] DRW_VRAMWDATA,
    output logic              DATAVALID,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_EMPTY,
    output logic              ALMOST_FULL,
    output logic              BURST_RDY,
    output logic [CW-1:0]     DATA_COUNT,
    output logic              BUF_OVER,
    output logic              BUF_UNDER,
    output logic              ERR_OVER,
    output logic              ERR_UNDER
);

    localparam int unsigned AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [CW-1:0] BURST_C  = CW'(BURST_LEN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count_next;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] data_next;
    logic              valid_next;

    always_comb begin
        rd_acc      = BUF_RD && !EMPTY;
        wr_acc      = BUF_WR && (!FULL || rd_acc);
        count_next  = DATA_COUNT;
        if (wr_acc && !rd_acc) begin
            count_next = DATA_COUNT + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_next = DATA_COUNT - 1'b1;
        end
        rd_ptr_next = rd_acc ? rd_ptr + 1'b1 : rd_ptr;

        data_next  = DRW_VRAMWDATA;
        valid_next = 1'b0;
        if (FWFT != 0) begin
            // Head after the edge: the word being written this cycle if the new
            // read pointer lands on it, otherwise it is already in the RAM.
            valid_next = (count_next != '0);
            if (count_next != '0) begin
                data_next = (wr_acc && (rd_ptr_next == wr_ptr)) ? PIXEL_DATA
                                                                : mem[rd_ptr_next];
            end
        end else if (rd_acc) begin
            valid_next = 1'b1;
            data_next  = mem[rd_ptr];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc && !INIT) begin
            mem[wr_ptr] <= PIXEL_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            DATA_COUNT    <= '0;
            EMPTY         <= 1'b1;
            FULL          <= 1'b0;
            ALMOST_EMPTY  <= 1'b1;
            ALMOST_FULL   <= 1'b0;
            BURST_RDY     <= 1'b0;
            BUF_OVER      <= 1'b0;
            BUF_UNDER     <= 1'b0;
            ERR_OVER      <= 1'b0;
            ERR_UNDER     <= 1'b0;
            DATAVALID     <= 1'b0;
            DRW_VRAMWDATA <= '0;
        end else if (INIT) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            DATA_COUNT    <= '0;
            EMPTY         <= 1'b1;
            FULL          <= 1'b0;
            ALMOST_EMPTY  <= 1'b1;
            ALMOST_FULL   <= 1'b0;
            BURST_RDY     <= 1'b0;
            BUF_OVER      <= 1'b0;
            BUF_UNDER     <= 1'b0;
            ERR_OVER      <= 1'b0;
            ERR_UNDER     <= 1'b0;
            DATAVALID     <= 1'b0;
            DRW_VRAMWDATA <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr        <= rd_ptr_next;
            DATA_COUNT    <= count_next;
            EMPTY         <= (count_next == '0);
            FULL          <= (count_next == DEPTH_C);
            ALMOST_EMPTY  <= (count_next <= AEMPTY_C);
            ALMOST_FULL   <= (count_next >= AFULL_C);
            BURST_RDY     <= (count_next >= BURST_C);
            BUF_OVER      <= BUF_WR && !wr_acc;
            BUF_UNDER     <= BUF_RD && EMPTY;
            // A fresh error in the clearing cycle keeps the sticky flag set.
            ERR_OVER      <= (BUF_WR && !wr_acc) || (ERR_OVER && !ERR_CLR);
            ERR_UNDER     <= (BUF_RD && EMPTY) || (ERR_UNDER && !ERR_CLR);
            DATAVALID     <= valid_next;
            DRW_VRAMWDATA <= data_next;
        end
    end

endmodule
